// File: rtl/can_rx_fifo.sv
// can_rx_fifo: receive-side frame buffer behind the CAN controller.
// Holds up to 2**DEPTH_LOG2 frames and presents the oldest one to the CPU
// on the 32-bit cs/rs/bytesel register port.
// Optional acceptance filter (FMATCH/FMASK at rs=4/5) built only when
// CAN_RX_FIFO_FILTER_EN is defined; otherwise every frame is accepted.
//
// Handshake: frm_stb is a one-cycle strobe carrying a complete frame; there is
// no back-pressure. frm_ack pulses exactly one cycle after every strobe, whether
// the frame was stored, dropped on overflow, or rejected by the filter.
module can_rx_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frm_stb,
  input  logic [28:0] frm_id,
  input  logic        frm_ext,
  input  logic        frm_rtr,
  input  logic [3:0]  frm_dlc,
  input  logic [63:0] frm_data,
  output logic        frm_ack,
  input  logic        cs,
  input  logic [2:0]  rs,
  input  logic [3:0]  bytesel,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  // Entry layout: {ext, rtr, id[28:0], dlc[3:0], data[63:0]}
  logic [98:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ovf;
  logic                  r_ack;
  logic                  r_irq;
  logic [1:0]            r_irqen;

  logic        w_empty;
  logic        w_full;
  logic        w_stat_wr;
  logic        w_pop;
  logic        w_clr_ovf;
  logic        w_accept;
  logic        w_push;
  logic        w_drop;
  logic [98:0] w_head;
  logic [7:0]  w_cnt8;
  logic        w_unused_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_stat_wr = cs & (rs == 3'd1);
  assign w_pop     = w_stat_wr & bytesel[0] & d[0] & ~w_empty;
  assign w_clr_ovf = w_stat_wr & bytesel[0] & d[1];
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push    = frm_stb & w_accept & (~w_full | w_pop);
  assign w_drop    = frm_stb & w_accept & w_full & ~w_pop;
  // Head fields read as zero while empty (storage is never reset).
  assign w_head    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign w_cnt8    = 8'(r_count);
  assign frm_ack   = r_ack;
  assign irq       = r_irq;
  // Write-data bits and byte lanes that no register consumes.
  assign w_unused_ok = ^{d, bytesel};

`ifdef CAN_RX_FIFO_FILTER_EN
  logic        r_m_ext;
  logic [28:0] r_m_id;
  logic        r_k_ext;
  logic [28:0] r_k_id;
  logic        w_fwr;

  assign w_fwr    = cs & (bytesel == 4'b1111);
  assign w_accept = (((frm_id ^ r_m_id) & r_k_id) == '0) &
                    (~r_k_ext | (frm_ext == r_m_ext));

  // Filter registers: full 32-bit writes only; zero means accept-all.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_ext <= 1'b0;
      r_m_id  <= '0;
      r_k_ext <= 1'b0;
      r_k_id  <= '0;
    end else if (w_fwr) begin
      if (rs == 3'd4) begin
        r_m_ext <= d[31];
        r_m_id  <= d[28:0];
      end
      if (rs == 3'd5) begin
        r_k_ext <= d[31];
        r_k_id  <= d[28:0];
      end
    end
  end
`else
  assign w_accept = 1'b1;
`endif

  // Frame storage write; not reset, contents behind rd_ptr are don't-care.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= {frm_ext, frm_rtr, frm_id, frm_dlc, frm_data};
    end
  end

  // Pointers, occupancy, sticky overflow, irq enable, ack and irq outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_irqen  <= 2'b00;
      r_ack    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A new drop in the same cycle as a clear keeps ovf set.
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_clr_ovf) r_ovf <= 1'b0;
      if (w_stat_wr && bytesel[3]) r_irqen <= d[31:30];
      r_ack <= frm_stb;
      r_irq <= (r_irqen[0] & ~w_empty) | (r_irqen[1] & r_ovf);
    end
  end

  // Combinational register read mux; zero when not selected.
  always_comb begin
    q = '0;
    if (cs) begin
      case (rs)
        3'd0: q = {w_head[98], w_head[97], 1'b0, w_head[96:68]};
        3'd1: q = {r_irqen, 11'b0, r_ovf, w_full, w_empty, w_cnt8,
                   4'b0, w_head[67:64]};
        3'd2: q = w_head[31:0];
        3'd3: q = w_head[63:32];
`ifdef CAN_RX_FIFO_FILTER_EN
        3'd4: q = {r_m_ext, 2'b0, r_m_id};
        3'd5: q = {r_k_ext, 2'b0, r_k_id};
`endif
        default: q = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_can_rx_fifo.sv
// tb_can_rx_fifo: self-checking bench for can_rx_fifo (DEPTH_LOG2 = 2).
// Frames expected in the FIFO are queued when driven and compared against
// the head registers when popped. Filter tests run when
// CAN_RX_FIFO_FILTER_EN is defined.
module tb_can_rx_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frm_stb = 1'b0;
  logic [28:0] frm_id = '0;
  logic        frm_ext = 1'b0;
  logic        frm_rtr = 1'b0;
  logic [3:0]  frm_dlc = '0;
  logic [63:0] frm_data = '0;
  logic        frm_ack;
  logic        cs = 1'b0;
  logic [2:0]  rs = '0;
  logic [3:0]  bytesel = '0;
  logic [31:0] d = '0;
  logic [31:0] q;
  logic        irq;

  can_rx_fifo #(.DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .frm_stb(frm_stb), .frm_id(frm_id),
    .frm_ext(frm_ext), .frm_rtr(frm_rtr), .frm_dlc(frm_dlc),
    .frm_data(frm_data), .frm_ack(frm_ack), .cs(cs), .rs(rs),
    .bytesel(bytesel), .d(d), .q(q), .irq(irq)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [98:0] exp_q[$];
  int          m_count = 0;
  logic        m_ovf = 1'b0;
  logic [1:0]  m_irqen = 2'b00;
  logic        f_m_ext = 1'b0;
  logic [28:0] f_m_id = '0;
  logic        f_k_ext = 1'b0;
  logic [28:0] f_k_id = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic tb_accept(input logic [28:0] id, input logic ext);
    return (((id ^ f_m_id) & f_k_id) == 29'd0) && (!f_k_ext || (ext == f_m_ext));
  endfunction

  function automatic logic [31:0] exp_status();
    logic [3:0] dlc;
    logic [98:0] e;
    dlc = 4'd0;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      dlc = e[67:64];
    end
    return {m_irqen, 11'b0, m_ovf, (m_count == DEPTH), (m_count == 0),
            8'(m_count), 4'b0, dlc};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frm_stb = 1'b1;       // strobe in the reset cycle must be lost
    frm_id = 29'h7;
    @(negedge clk);
    frm_stb = 1'b0;
    check("reset_no_ack", {31'b0, frm_ack}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_ovf = 1'b0;
    m_irqen = 2'b00;
    f_m_ext = 1'b0; f_m_id = '0; f_k_ext = 1'b0; f_k_id = '0;
  endtask

  task automatic read_reg(input logic [2:0] r, output logic [31:0] v);
    @(negedge clk);
    cs = 1'b1; rs = r; bytesel = 4'b0000; d = '0;
    #1 v = q;
    cs = 1'b0;
  endtask

  task automatic reg_write(input logic [2:0] r, input logic [3:0] bs,
                           input logic [31:0] dat);
    @(negedge clk);
    cs = 1'b1; rs = r; bytesel = bs; d = dat;
    @(negedge clk);
    cs = 1'b0; bytesel = 4'b0000; d = '0;
  endtask

  // Drives one strobe; wd != 0 also writes STATUS (bytesel[0]) in that cycle.
  task automatic push_frame(input logic [28:0] id, input logic ext,
                            input logic rtr, input logic [3:0] dlc,
                            input logic [63:0] data, input logic [31:0] wd);
    logic pop_ok;
    @(negedge clk);
    frm_stb = 1'b1; frm_id = id; frm_ext = ext; frm_rtr = rtr;
    frm_dlc = dlc; frm_data = data;
    if (wd != 0) begin
      cs = 1'b1; rs = 3'd1; bytesel = 4'b0001; d = wd;
    end
    pop_ok = wd[0] && (m_count > 0);
    if (wd[1]) m_ovf = 1'b0;
    if (tb_accept(id, ext)) begin
      if (m_count < DEPTH || pop_ok) begin
        exp_q.push_back({ext, rtr, id, dlc, data});
        m_count++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (pop_ok) begin
      void'(exp_q.pop_front());
      m_count--;
    end
    @(negedge clk);
    frm_stb = 1'b0; cs = 1'b0; bytesel = 4'b0000; d = '0;
    check("frm_ack", {31'b0, frm_ack}, 32'd1);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] v;
    read_reg(3'd1, v);
    check(tag, v, exp_status());
  endtask

  task automatic pop_and_check(input string tag);
    logic [31:0] v;
    logic [98:0] e;
    e = exp_q[0];
    read_reg(3'd0, v);
    check({tag, "_id"}, v, {e[98], e[97], 1'b0, e[96:68]});
    read_reg(3'd2, v);
    check({tag, "_d0"}, v, e[31:0]);
    read_reg(3'd3, v);
    check({tag, "_d1"}, v, e[63:32]);
    check_status({tag, "_st"});
    reg_write(3'd1, 4'b0001, 32'd1);
    void'(exp_q.pop_front());
    m_count--;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;

    // Reset state
    do_reset();
    check("rst_status", exp_status(), 32'h0001_0000);
    check_status("rst_status_dut");
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_ack", {31'b0, frm_ack}, 32'd0);

    // Single frame, register map
    push_frame(29'h123, 1'b0, 1'b0, 4'd8, 64'h8877665544332211, 32'd0);
    @(negedge clk);
    check("ack_once", {31'b0, frm_ack}, 32'd0);
    read_reg(3'd0, v); check("t1_head_id", v, 32'h0000_0123);
    read_reg(3'd1, v); check("t1_status", v, 32'h0000_0108);
    read_reg(3'd2, v); check("t1_data0", v, 32'h4433_2211);
    read_reg(3'd3, v); check("t1_data1", v, 32'h8877_6655);
    read_reg(3'd6, v); check("t1_rs6", v, 32'd0);
    pop_and_check("t1_pop");
    check_status("t1_after");

    // Fill, overflow, drain in order
    do_reset();
    for (int i = 1; i <= 5; i++)
      push_frame(29'(i), 1'b0, i[0], 4'(i), rnd64(), 32'd0);
    read_reg(3'd1, v); check("t2_full_status", v, 32'h0006_0401);
    check_status("t2_full_model");
    for (int i = 0; i < 4; i++) pop_and_check("t2_pop");
    read_reg(3'd1, v); check("t2_empty_status", v, 32'h0005_0000);
    read_reg(3'd0, v); check("t2_empty_head", v, 32'd0);

    // Reset with frames stored discards them
    push_frame(29'h1ABCDEF, 1'b1, 1'b1, 4'd3, rnd64(), 32'd0);
    do_reset();
    check_status("midburst_reset");

    // Full FIFO with simultaneous push and pop
    for (int i = 1; i <= 4; i++)
      push_frame(29'(i), 1'b0, 1'b0, 4'(i), rnd64(), 32'd0);
    push_frame(29'h9, 1'b1, 1'b0, 4'd9, rnd64(), 32'd1);
    read_reg(3'd1, v); check("t3_status", v, 32'h0002_0402);
    for (int i = 0; i < 4; i++) pop_and_check("t3_pop");
    check_status("t3_empty");

    // Pop on empty is ignored
    do_reset();
    reg_write(3'd1, 4'b0001, 32'd1);
    reg_write(3'd1, 4'b0001, 32'd1);
    check_status("t4_empty_pop");
    push_frame(29'h55, 1'b0, 1'b1, 4'd2, 64'h0123456789ABCDEF, 32'd0);
    read_reg(3'd0, v); check("t4_head", v, 32'h4000_0055);
    pop_and_check("t4_pop");
    // Pointer wrap over several laps
    for (int i = 0; i < 9; i++) begin
      push_frame(29'($urandom_range(0, 2047)), 1'b0, 1'b0,
                 4'($urandom_range(0, 8)), rnd64(), 32'd0);
      push_frame(29'($urandom), 1'b1, 1'b0, 4'($urandom_range(0, 15)), rnd64(), 32'd0);
      pop_and_check("t4_wrap");
    end
    while (exp_q.size() > 0) pop_and_check("t4_drain");

    // irqen=01: non-empty interrupt
    do_reset();
    reg_write(3'd1, 4'b1000, 32'h4000_0000);
    m_irqen = 2'b01;
    check_status("t5_irqen");
    push_frame(29'h42, 1'b0, 1'b0, 4'd1, rnd64(), 32'd0);
    check("t5_irq_ack_cycle", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("t5_irq_set", {31'b0, irq}, 32'd1);
    pop_and_check("t5_pop");
    @(negedge clk);
    check("t5_irq_clr", {31'b0, irq}, 32'd0);

    // irqen=10: overflow interrupt, clear-vs-drop priority
    do_reset();
    reg_write(3'd1, 4'b1000, 32'h8000_0000);
    m_irqen = 2'b10;
    for (int i = 1; i <= 5; i++)
      push_frame(29'(i), 1'b0, 1'b0, 4'd0, rnd64(), 32'd0);
    @(negedge clk);
    check("t6_irq_ovf", {31'b0, irq}, 32'd1);
    push_frame(29'h6, 1'b0, 1'b0, 4'd0, rnd64(), 32'd2);
    check_status("t6_set_wins");
    repeat (3) @(negedge clk);
    check("t6_irq_hold", {31'b0, irq}, 32'd1);
    reg_write(3'd1, 4'b0001, 32'd2);
    m_ovf = 1'b0;
    @(negedge clk);
    check("t6_irq_cleared", {31'b0, irq}, 32'd0);
    check_status("t6_after_clr");

`ifdef CAN_RX_FIFO_FILTER_EN
    // Acceptance filter
    do_reset();
    reg_write(3'd4, 4'b1111, 32'h0000_0120);
    reg_write(3'd5, 4'b1111, 32'h0000_07F0);
    f_m_id = 29'h120; f_k_id = 29'h7F0;
    read_reg(3'd4, v); check("f_fmatch", v, 32'h0000_0120);
    read_reg(3'd5, v); check("f_fmask", v, 32'h0000_07F0);
    push_frame(29'h12F, 1'b0, 1'b0, 4'd4, rnd64(), 32'd0);
    push_frame(29'h130, 1'b0, 1'b0, 4'd4, rnd64(), 32'd0);
    read_reg(3'd1, v); check("f_status", v, 32'h0000_0104);
    pop_and_check("f_pop");
    reg_write(3'd5, 4'b1111, 32'h8000_0000);
    reg_write(3'd4, 4'b1111, 32'h8000_0000);
    f_m_ext = 1'b1; f_m_id = '0; f_k_ext = 1'b1; f_k_id = '0;
    for (int i = 0; i < 3; i++)
      push_frame(29'($urandom_range(0, 2047)), 1'b0, 1'b0, 4'd1, rnd64(), 32'd0);
    read_reg(3'd1, v); check("f_std_rejected", v, 32'h0001_0000);
    push_frame(29'h1234567, 1'b1, 1'b0, 4'd5, rnd64(), 32'd0);
    pop_and_check("f_ext_pop");
`else
    do_reset();
    reg_write(3'd4, 4'b1111, 32'hFFFF_FFFF);
    reg_write(3'd5, 4'b1111, 32'hFFFF_FFFF);
    read_reg(3'd4, v); check("nf_rs4", v, 32'd0);
    read_reg(3'd5, v); check("nf_rs5", v, 32'd0);
    push_frame(29'h130, 1'b0, 1'b0, 4'd4, rnd64(), 32'd0);
    pop_and_check("nf_pop");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
